// File: rtl/vector_shift_pipe_if.sv
// Handshake and data bundle for vector_shift_pipe: launch fields, register-file read port and result stream.
// The master side (launcher / register file) drives i_*; the slave side (shift pipe) drives o_*.
interface vector_shift_pipe_if #(
   parameter int WIDTH  = 64,
   parameter int MAX_VL = 64
);
   localparam int VL_W = $clog2(MAX_VL) + 1;

   logic              i_start;
   logic [6:0]        i_instr;
   logic [VL_W-1:0]   i_vl;
   logic [2:0]        i_j;
   logic [2:0]        i_k;
   logic [23:0]       i_ak;
   logic [2:0]        o_rd_j;
   logic [VL_W-1:0]   o_rd_idx;
   logic              o_rd_en;
   logic [WIDTH-1:0]  i_vdata;
   logic [WIDTH-1:0]  o_result;
   logic              o_valid;
   logic              o_busy;
   logic              o_done;

   modport master (
      output i_start, i_instr, i_vl, i_j, i_k, i_ak, i_vdata,
      input  o_rd_j, o_rd_idx, o_rd_en, o_result, o_valid, o_busy, o_done
   );

   modport slave (
      input  i_start, i_instr, i_vl, i_j, i_k, i_ak, i_vdata,
      output o_rd_j, o_rd_idx, o_rd_en, o_result, o_valid, o_busy, o_done
   );
endinterface

// File: rtl/vector_shift_pipe.sv
// Vector shift unit: single/double left/right shifts per element; arithmetic right only with VSHIFT_ARITH_EN.
// Latency: element i read in S+1+i, result in S+4+i, one per clock; o_done with the last result.
// Backpressure: none downstream; i_start is ignored while o_busy is high.
module vector_shift_pipe #(
   parameter int WIDTH  = 64,
   parameter int MAX_VL = 64
) (
   input logic             clk,
   input logic             rst,
   vector_shift_pipe_if.slave bus
);
   localparam int VL_W = $clog2(MAX_VL) + 1;
   localparam int C_W  = $clog2(2 * WIDTH) + 1;

   localparam logic [6:0] OP_SL = 7'b1101000;
   localparam logic [6:0] OP_SR = 7'b1101001;
   localparam logic [6:0] OP_DL = 7'b1100010;
   localparam logic [6:0] OP_DR = 7'b1100011;
`ifdef VSHIFT_ARITH_EN
   localparam logic [6:0] OP_AR = 7'b1101011;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [6:0]        op_q;
   logic [2:0]        j_q;
   logic [VL_W-1:0]   vle_q;
   logic [VL_W-1:0]   rd_idx_q;
   logic [C_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]  d0_q, d1_q, d2_q;
   logic [WIDTH-1:0]  res_q, shift_res;
   logic [2*WIDTH-1:0] dl_cat, dr_cat;
   logic              v0_q, v1_q, l0_q, l1_q, valid_q, done_q;
   logic              accept, rd_en, rd_last;

   assign accept  = (state_q == ST_IDLE) && bus.i_start;
   assign rd_en   = (state_q == ST_READ);
   assign rd_last = rd_en && (rd_idx_q == vle_q - VL_W'(1));

   // Count saturates at 2*WIDTH, which already clears every shift form.
   always_comb begin
      cnt_d = C_W'(1);
      if (bus.i_k != 3'd0) begin
         if (bus.i_ak >= 24'(2 * WIDTH)) cnt_d = C_W'(2 * WIDTH);
         else                            cnt_d = bus.i_ak[C_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept)  state_d = ST_READ;
         ST_READ:  if (rd_last) state_d = ST_DRAIN;
         ST_DRAIN: if (done_q)  state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         j_q      <= '0;
         vle_q    <= '0;
         cnt_q    <= '0;
         rd_idx_q <= '0;
      end else if (accept) begin
         op_q     <= bus.i_instr;
         j_q      <= bus.i_j;
         vle_q    <= (bus.i_vl == '0) ? VL_W'(MAX_VL) : bus.i_vl;
         cnt_q    <= cnt_d;
         rd_idx_q <= '0;
      end else if (rd_en && !rd_last) begin
         rd_idx_q <= rd_idx_q + VL_W'(1);
      end
   end

   // d0/d1/d2 hold V[i+1], V[i], V[i-1] while element i is computed; idle slots
   // capture zero so both vector ends see zero neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         d0_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         l0_q    <= 1'b0;
         l1_q    <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         d0_q    <= rd_en ? bus.i_vdata : '0;
         d1_q    <= d0_q;
         d2_q    <= d1_q;
         v0_q    <= rd_en;
         v1_q    <= v0_q;
         l0_q    <= rd_last;
         l1_q    <= l0_q;
         valid_q <= v1_q;
         done_q  <= l1_q;
         if (v1_q) res_q <= shift_res;
      end
   end

   always_comb begin
      dl_cat    = {d1_q, d0_q} << cnt_q;
      dr_cat    = {d2_q, d1_q} >> cnt_q;
      shift_res = '0;
      case (op_q)
         OP_SL: if (cnt_q < C_W'(WIDTH)) shift_res = d1_q << cnt_q;
         OP_SR: if (cnt_q < C_W'(WIDTH)) shift_res = d1_q >> cnt_q;
         OP_DL: shift_res = dl_cat[2*WIDTH-1:WIDTH];
         OP_DR: shift_res = dr_cat[WIDTH-1:0];
`ifdef VSHIFT_ARITH_EN
         OP_AR: begin
            if (cnt_q < C_W'(WIDTH)) shift_res = $signed(d1_q) >>> cnt_q;
            else                     shift_res = {WIDTH{d1_q[WIDTH-1]}};
         end
`endif
         default: shift_res = '0;
      endcase
   end

   assign bus.o_rd_j   = j_q;
   assign bus.o_rd_idx = rd_idx_q;
   assign bus.o_rd_en  = rd_en;
   assign bus.o_result = res_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_busy   = (state_q != ST_IDLE);
   assign bus.o_done   = done_q;
endmodule
